// File: rtl/uart_cmd_pkg.sv
// Shared types, frame codes and frame helpers for the UART command host.
package uart_cmd_pkg;

    localparam logic [7:0] FRM_WR      = 8'hAA;
    localparam logic [7:0] FRM_RD      = 8'hBB;
    localparam logic [7:0] FRM_ALU_OP  = 8'hCC;
    localparam logic [7:0] FRM_ALU_NOP = 8'hDD;

    typedef enum logic [1:0] {
        CMD_WR      = 2'd0,
        CMD_RD      = 2'd1,
        CMD_ALU_OP  = 2'd2,
        CMD_ALU_NOP = 2'd3
    } cmd_type_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_RSP,
        ST_DONE
    } state_t;

    typedef struct packed {
        cmd_type_t  typ;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] op_a;
        logic [7:0] op_b;
        logic [3:0] fun;
    } cmd_t;

    // Number of bytes in the outgoing frame.
    function automatic logic [2:0] frame_len(input cmd_type_t t);
        logic [2:0] n;
        case (t)
            CMD_WR:     n = 3'd3;
            CMD_RD:     n = 3'd2;
            CMD_ALU_OP: n = 3'd4;
            default:    n = 3'd2;
        endcase
        return n;
    endfunction

    // Number of response bytes expected back.
    function automatic logic [1:0] rsp_len(input cmd_type_t t);
        logic [1:0] n;
        case (t)
            CMD_WR:  n = 2'd0;
            CMD_RD:  n = 2'd1;
            default: n = 2'd2;
        endcase
        return n;
    endfunction

    // Frame byte at position idx (first transmitted byte is idx 0).
    function automatic logic [7:0] frame_byte(input cmd_t c, input logic [1:0] idx);
        logic [7:0] b;
        b = 8'h00;
        case (c.typ)
            CMD_WR: begin
                case (idx)
                    2'd0:    b = FRM_WR;
                    2'd1:    b = c.addr;
                    default: b = c.wdata;
                endcase
            end
            CMD_RD: begin
                b = (idx == 2'd0) ? FRM_RD : c.addr;
            end
            CMD_ALU_OP: begin
                case (idx)
                    2'd0:    b = FRM_ALU_OP;
                    2'd1:    b = c.op_a;
                    2'd2:    b = c.op_b;
                    default: b = {4'h0, c.fun};
                endcase
            end
            default: begin
                b = (idx == 2'd0) ? FRM_ALU_NOP : {4'h0, c.fun};
            end
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Saturating idle counter; flags when the response gap reaches its limit.
module uart_cmd_timeout
    import uart_cmd_pkg::*;
#(
    parameter int unsigned TO_W        = 16,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TO_W-1:0] CNT_MAX = '1;
    localparam logic [TO_W-1:0] CNT_TERM = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] cnt;

    // Count idle cycles while enabled, hold at all-ones instead of wrapping.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != CNT_MAX)) begin
            cnt <= cnt + TO_W'(1);
        end
    end

    assign expired = (cnt >= CNT_TERM);

endmodule

// File: rtl/uart_cmd_host.sv
// Host-side command initiator: serializes one command frame and collects its response.
module uart_cmd_host
    import uart_cmd_pkg::*;
#(
    parameter int unsigned TO_W        = 16,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_type,
    input  logic [7:0]  cmd_addr,
    input  logic [7:0]  cmd_wdata,
    input  logic [7:0]  cmd_op_a,
    input  logic [7:0]  cmd_op_b,
    input  logic [3:0]  cmd_fun,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_timeout,
    output logic        busy
);

    state_t     state;
    cmd_t       cmd;
    cmd_t       cmd_in;
    logic [1:0] idx;
    logic       rx_idx;
    logic [7:0] rx_lo;
    logic       to_clr;
    logic       to_en;
    logic       to_expired;

    assign cmd_in = '{typ:   cmd_type_t'(cmd_type),
                      addr:  cmd_addr,
                      wdata: cmd_wdata,
                      op_a:  cmd_op_a,
                      op_b:  cmd_op_b,
                      fun:   cmd_fun};

    // Counter only runs while waiting; every received byte reloads it.
    assign to_en  = (state == ST_WAIT_RSP);
    assign to_clr = !to_en || rx_valid;

    uart_cmd_timeout #(
        .TO_W        (TO_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .CLK     (CLK),
        .RST     (RST),
        .clr     (to_clr),
        .en      (to_en),
        .expired (to_expired)
    );

    // Command FSM with registered handshake and response outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= ST_IDLE;
            cmd         <= '0;
            idx         <= 2'd0;
            rx_idx      <= 1'b0;
            rx_lo       <= 8'h00;
            cmd_ready   <= 1'b1;
            tx_byte     <= 8'h00;
            tx_valid    <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= 16'h0000;
            rsp_timeout <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd       <= cmd_in;
                        idx       <= 2'd0;
                        rx_idx    <= 1'b0;
                        tx_byte   <= frame_byte(cmd_in, 2'd0);
                        tx_valid  <= 1'b1;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (tx_ready) begin
                        if ((3'(idx) + 3'd1) == frame_len(cmd.typ)) begin
                            tx_valid <= 1'b0;
                            if (rsp_len(cmd.typ) != 2'd0) begin
                                state <= ST_WAIT_RSP;
                            end else begin
                                state       <= ST_DONE;
                                rsp_valid   <= 1'b1;
                                rsp_data    <= 16'h0000;
                                rsp_timeout <= 1'b0;
                            end
                        end else begin
                            idx     <= idx + 2'd1;
                            tx_byte <= frame_byte(cmd, idx + 2'd1);
                        end
                    end
                end
                ST_WAIT_RSP: begin
                    // A byte arriving on the terminal count still wins.
                    if (rx_valid) begin
                        if (!rx_idx) begin
                            rx_lo <= rx_byte;
                        end
                        if ((2'(rx_idx) + 2'd1) == rsp_len(cmd.typ)) begin
                            state       <= ST_DONE;
                            rsp_valid   <= 1'b1;
                            rsp_timeout <= 1'b0;
                            rsp_data    <= (cmd.typ == CMD_RD) ? {8'h00, rx_byte}
                                                               : {rx_byte, rx_lo};
                        end else begin
                            rx_idx <= 1'b1;
                        end
                    end else if (to_expired) begin
                        state       <= ST_DONE;
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_data    <= 16'h0000;
                    end
                end
                ST_DONE: begin
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
